// File: rtl/veer_types.sv
// rtl/veer_types.sv - shared types and constants for the EXU posit sequencer
//
// Purpose: operation and state encodings used by exu_posu_sched and its
// watchdog, plus the posit NaR constant and a two's-complement helper.
package veer_types;

  // Request opcode as presented by decode/issue.
  typedef enum logic [1:0] {
    POSU_ADD = 2'b00,
    POSU_SUB = 2'b01,
    POSU_MUL = 2'b10,
    POSU_DIV = 2'b11
  } posu_op_e;

  typedef enum logic [2:0] {
    POSU_IDLE   = 3'd0,
    POSU_LAUNCH = 3'd1,
    POSU_WAIT   = 3'd2,
    POSU_DRAIN  = 3'd3,
    POSU_RESP   = 3'd4
  } posu_sched_state_e;

  // Posit Not-a-Real; also the value reported on a watchdog timeout.
  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

  // Posit negation is plain two's-complement; NaR maps onto itself.
  function automatic logic [31:0] posit_neg(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/exu_posu_wdog.sv
// rtl/exu_posu_wdog.sv - clear/enable watchdog counter for multi-cycle posit ops
//
// Ports:
//   clk, rst_l : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over enable)
//   enable     : count up by one this cycle
//   expire     : counter currently equals TIMEOUT-1
module exu_posu_wdog #(
  parameter int TIMEOUT = 64,
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count == CNT_W'(TIMEOUT - 1));
  assign expire     = w_at_limit;

  // Holding at the limit keeps the counter from wrapping if the owner
  // lingers in a counting state after expiry.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_limit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exu_posu_sched.sv
// rtl/exu_posu_sched.sv - sequencer between issue and the posit add/mul/div units
//
// Ports:
//   clk, rst_l, scan_mode        : clock, async active-low reset, scan control
//   flush                        : kill the in-flight posit op
//   req_valid/req_ready          : request handshake (ready only when idle)
//   req_op/req_a/req_b/req_tag   : opcode, operands, destination tag
//   unit_a/unit_b                : operands broadcast to all units (b negated for sub)
//   add/mul/div_start            : one-cycle start pulses
//   add/mul/div_done, *_out      : unit completion and results
//   res_valid/res_ready          : result handshake
//   res_data/res_tag/res_err     : result, its tag, watchdog-timeout flag
//   posu_stall                   : sequencer busy
module exu_posu_sched
  import veer_types::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             scan_mode,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  output logic             add_start,
  output logic             mul_start,
  output logic             div_start,
  input  logic             add_done,
  input  logic             mul_done,
  input  logic             div_done,
  input  logic [31:0]      add_out,
  input  logic [31:0]      mul_out,
  input  logic [31:0]      div_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             posu_stall
);

  posu_sched_state_e r_state;
  posu_sched_state_e w_next;

  posu_op_e         r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_res_data;
  logic             r_res_err;

  posu_op_e    w_req_op;
  logic        w_sel_add;
  logic        w_sel_mul;
  logic        w_sel_div;
  logic        w_sel_done;
  logic [31:0] w_sel_out;
  logic        w_accept;
  logic        w_cap_done;
  logic        w_cap_tmo;
  logic        w_wd_clear;
  logic        w_wd_enable;
  logic        w_expire;
  logic        w_unused_scan;

  // No scan-muxed flops live in this block; the pin is kept for interface parity.
  assign w_unused_scan = scan_mode;

  assign w_req_op = posu_op_e'(req_op);

  // Subtraction runs on the add unit with a pre-negated B operand.
  assign w_sel_add = (r_op == POSU_ADD) || (r_op == POSU_SUB);
  assign w_sel_mul = (r_op == POSU_MUL);
  assign w_sel_div = (r_op == POSU_DIV);

  assign w_sel_done = (w_sel_add & add_done) | (w_sel_mul & mul_done) | (w_sel_div & div_done);

  always_comb begin
    w_sel_out = add_out;
    if (w_sel_mul) w_sel_out = mul_out;
    if (w_sel_div) w_sel_out = div_out;
  end

  // Timer sits at zero in IDLE, so LAUNCH is count 0 and expiry lands
  // TIMEOUT-1 cycles after the start pulse.
  assign w_wd_clear  = (r_state == POSU_IDLE);
  assign w_wd_enable = (r_state == POSU_LAUNCH) || (r_state == POSU_WAIT) ||
                       (r_state == POSU_DRAIN);

  exu_posu_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (w_wd_clear),
    .enable (w_wd_enable),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= POSU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flush is examined first in every state that honours it.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_cap_done = 1'b0;
    w_cap_tmo  = 1'b0;
    add_start  = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    case (r_state)
      POSU_IDLE: begin
        if (req_valid && !flush) begin
          w_accept = 1'b1;
          w_next   = POSU_LAUNCH;
        end
      end
      POSU_LAUNCH: begin
        if (flush) begin
          w_next = POSU_IDLE;
        end else begin
          add_start = w_sel_add;
          mul_start = w_sel_mul;
          div_start = w_sel_div;
          if (w_sel_done) begin
            w_cap_done = 1'b1;
            w_next     = POSU_RESP;
          end else begin
            w_next = POSU_WAIT;
          end
        end
      end
      POSU_WAIT: begin
        if (flush) begin
          // A unit that finishes in the flush cycle has nothing left to drain.
          w_next = w_sel_done ? POSU_IDLE : POSU_DRAIN;
        end else if (w_sel_done) begin
          w_cap_done = 1'b1;
          w_next     = POSU_RESP;
        end else if (w_expire) begin
          w_cap_tmo = 1'b1;
          w_next    = POSU_RESP;
        end
      end
      POSU_DRAIN: begin
        // Wait out the killed op so the unit is quiet before the next start.
        if (w_sel_done || w_expire) begin
          w_next = POSU_IDLE;
        end
      end
      POSU_RESP: begin
        if (flush || res_ready) begin
          w_next = POSU_IDLE;
        end
      end
      default: w_next = POSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_op       <= POSU_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= w_req_op;
        r_a   <= req_a;
        r_b   <= (w_req_op == POSU_SUB) ? posit_neg(req_b) : req_b;
        r_tag <= req_tag;
      end
      if (w_cap_done) begin
        r_res_data <= w_sel_out;
        r_res_err  <= 1'b0;
      end else if (w_cap_tmo) begin
        r_res_data <= POSIT_NAR;
        r_res_err  <= 1'b1;
      end
    end
  end

  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign req_ready  = (r_state == POSU_IDLE);
  assign posu_stall = (r_state != POSU_IDLE);
  assign res_valid  = (r_state == POSU_RESP);
  assign res_data   = r_res_data;
  assign res_tag    = r_tag;
  assign res_err    = r_res_err;

endmodule

// File: tb/tb_exu_posu_sched.sv
// tb/tb_exu_posu_sched.sv - self-checking bench for exu_posu_sched
module tb_exu_posu_sched;
  import veer_types::*;

  localparam int TAG_W = 5;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             scan_mode = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      unit_a, unit_b;
  logic             add_start, mul_start, div_start;
  logic             add_done = 1'b0, mul_done = 1'b0, div_done = 1'b0;
  logic [31:0]      add_out = '0, mul_out = '0, div_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             posu_stall;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  exu_posu_sched #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .unit_a(unit_a), .unit_b(unit_b),
    .add_start(add_start), .mul_start(mul_start), .div_start(div_start),
    .add_done(add_done), .mul_done(mul_done), .div_done(div_done),
    .add_out(add_out), .mul_out(mul_out), .div_out(div_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .posu_stall(posu_stall)
  );

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || posu_stall !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got rdy=%b stall=%b vld=%b want 1 0 0", req_ready, posu_stall, res_valid);
    end
    n_cmp++;
    if ({add_start, mul_start, div_start} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_start: got %b want 000", {add_start, mul_start, div_start});
    end
    n_cmp++;
    if (unit_a !== 32'h0 || unit_b !== 32'h0 || res_data !== 32'h0 || res_tag !== '0 || res_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: got a=%h b=%h d=%h t=%h e=%b want zeros", unit_a, unit_b, res_data, res_tag, res_err);
    end
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  // One full request: op issue, unit response after lat cycles from LAUNCH
  // (lat<0: never), optional stray mul_done, hold cycles of backpressure.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag, input int lat,
                       input logic [31:0] uout, input int hold, input bit stray);
    exp_t        e;
    int          k;
    int          exp_k;
    int          n_add, n_mul, n_div;
    bit          seen;
    logic [31:0] exp_b;
    e.data = (lat < 0) ? POSIT_NAR : uout;
    e.tag  = tag;
    e.err  = (lat < 0);
    exp_b  = (op == 2'b01) ? (32'h0 - b) : b;
    exp_k  = (lat < 0) ? TO : lat + 1;
    n_add = 0; n_mul = 0; n_div = 0; seen = 0;
    sb.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    add_out = (op[1] == 1'b0) ? uout : 32'h1111_1111;
    mul_out = (op == 2'b10) ? uout : 32'hDEAD_BEEF;
    div_out = (op == 2'b11) ? uout : 32'h2222_2222;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: got %b want 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (k = 0; k < 40; k++) begin
      add_done = (op[1] == 1'b0) && (k == lat);
      mul_done = ((op == 2'b10) && (k == lat)) || (stray && (k == 1) && (op != 2'b10));
      div_done = (op == 2'b11) && (k == lat);
      #1;
      if (res_valid) begin
        seen = 1;
        break;
      end
      n_add += int'(add_start);
      n_mul += int'(mul_start);
      n_div += int'(div_start);
      if (k == 0) begin
        n_cmp++;
        if (unit_a !== a || unit_b !== exp_b) begin
          n_bad++;
          $display("FAIL %s_operands: got a=%h b=%h want a=%h b=%h", name, unit_a, unit_b, a, exp_b);
        end
      end
      @(negedge clk);
    end
    add_done = 1'b0; mul_done = 1'b0; div_done = 1'b0;

    n_cmp++;
    if (!seen || k != exp_k) begin
      n_bad++;
      $display("FAIL %s_latency: got seen=%0d cycle=%0d want cycle=%0d", name, seen, k, exp_k);
    end
    n_cmp++;
    if (n_add != int'(op[1] == 1'b0) || n_mul != int'(op == 2'b10) || n_div != int'(op == 2'b11)) begin
      n_bad++;
      $display("FAIL %s_starts: got add=%0d mul=%0d div=%0d for op %0d", name, n_add, n_mul, n_div, op);
    end
    if (!seen) begin
      void'(sb.pop_front());
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      return;
    end

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        #1;
      end
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== sb[0].data || req_ready !== 1'b0 || posu_stall !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_hold%0d: got vld=%b d=%h rdy=%b stall=%b want 1 %h 0 1", name, h,
                 res_valid, res_data, req_ready, posu_stall, sb[0].data);
      end
    end
    res_ready = 1'b1;
    e = sb.pop_front();
    n_cmp++;
    if (res_data !== e.data || res_tag !== e.tag || res_err !== e.err) begin
      n_bad++;
      $display("FAIL %s_result: got d=%h t=%h e=%b want d=%h t=%h e=%b", name,
               res_data, res_tag, res_err, e.data, e.tag, e.err);
    end
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || posu_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_retire: got vld=%b rdy=%b stall=%b want 0 1 0", name, res_valid, req_ready, posu_stall);
    end
  endtask

  task automatic test_add();
    do_op("add", 2'b00, 32'h4000_0000, 32'h4000_0000, 5'd3, 3, 32'h4800_0000, 0, 1'b0);
  endtask

  task automatic test_sub();
    do_op("sub", 2'b01, 32'h1234_5678, 32'h4000_0000, 5'd7, 2, 32'h3000_0000, 0, 1'b0);
    do_op("sub_nar", 2'b01, 32'h4000_0000, 32'h8000_0000, 5'd8, 1, 32'h8000_0000, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op("bp_mul", 2'b10, 32'h5000_0000, 32'h3000_0000, 5'd12, 2, 32'h4C00_0000, 5, 1'b0);
  endtask

  task automatic test_zero_latency();
    do_op("div_zl", 2'b11, 32'h6000_0000, 32'h4000_0000, 5'd31, 0, 32'h6000_0001, 0, 1'b0);
  endtask

  task automatic test_stray_done();
    do_op("stray", 2'b00, 32'h4800_0000, 32'h3800_0000, 5'd17, 4, 32'h4A00_0000, 1, 1'b1);
  endtask

  task automatic test_timeout();
    do_op("timeout", 2'b00, 32'h4000_0000, 32'h4000_0000, 5'd21, -1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_flush_wait();
    int n_rv;
    n_rv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'h7000_0000; req_b = 32'h4000_0000; req_tag = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      flush    = (k == 2);
      div_done = (k == 4);
      #1;
      if (res_valid) n_rv++;
      if (k == 0) begin
        n_cmp++;
        if (div_start !== 1'b1) begin
          n_bad++;
          $display("FAIL flush_wait_start: got %b want 1", div_start);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (req_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL flush_wait_drain: got rdy=%b want 0", req_ready);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL flush_wait_ready: got rdy=%b want 1", req_ready);
        end
      end
      if (k < 5) @(negedge clk);
    end
    flush = 1'b0; div_done = 1'b0;
    n_cmp++;
    if (n_rv != 0) begin
      n_bad++;
      $display("FAIL flush_wait_novalid: got %0d valid cycles want 0", n_rv);
    end
  endtask

  task automatic test_flush_launch();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h4000_0000; req_b = 32'h4000_0000; req_tag = 5'd2;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (add_start !== 1'b0 || posu_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_launch_start: got start=%b stall=%b want 0 1", add_start, posu_stall);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_launch_idle: got rdy=%b vld=%b want 1 0", req_ready, res_valid);
    end
    // request and flush together: request is dropped
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || add_start !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle_drop: got rdy=%b start=%b want 1 0", req_ready, add_start);
    end
  endtask

  task automatic test_flush_resp();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'h4000_0000; req_b = 32'h4000_0000; req_tag = 5'd6;
    mul_out = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0; mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL flush_resp_pre: got vld=%b d=%h want 1 12345678", res_valid, res_data);
    end
    flush = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; res_ready = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_resp_drop: got vld=%b rdy=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'h0000_1234; req_b = 32'h0000_5678; req_tag = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (posu_stall !== 1'b1 || unit_a !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL rst_wait_pre: got stall=%b a=%h want 1 00001234", posu_stall, unit_a);
    end
    rst_l = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || posu_stall !== 1'b0 || res_valid !== 1'b0 ||
        {add_start, mul_start, div_start} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_async_ctl: got rdy=%b stall=%b vld=%b st=%b want 1 0 0 000",
               req_ready, posu_stall, res_valid, {add_start, mul_start, div_start});
    end
    n_cmp++;
    if (unit_a !== 32'h0 || unit_b !== 32'h0 || res_data !== 32'h0 || res_tag !== '0 || res_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async_data: got a=%h b=%h d=%h t=%h e=%b want zeros",
               unit_a, unit_b, res_data, res_tag, res_err);
    end
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_zero_latency();
    test_stray_done();
    test_timeout();
    test_flush_wait();
    test_flush_launch();
    test_flush_resp();
    test_reset_mid_wait();
    do_op("post_reset", 2'b11, 32'h5000_0000, 32'h4000_0000, 5'd1, 2, 32'h5000_0000, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
